// File: rtl/nbr_match_node.sv
// nbr_match_node: compares its own state against N_NEIGH neighbour states.
// One neighbour is checked per clock through a single shared equality
// comparator. The result is the number of equal neighbours plus a flag that
// says whether that count reaches a threshold.
// Optional feature macro NBR_MASK_EN adds a per-neighbour count mask
// (nbr_mask), which is captured together with start.
module nbr_match_node #(
    parameter int W       = 2,
    parameter int N_NEIGH = 4,
    parameter int CNT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 high,
    input  logic                 start,
    input  logic [W-1:0]         self_in,
    input  logic [N_NEIGH*W-1:0] nbr_in,
    input  logic [CNT_W-1:0]     thresh,
`ifdef NBR_MASK_EN
    input  logic [N_NEIGH-1:0]   nbr_mask,
`endif
    output logic                 busy,
    output logic                 out,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int IDX_W = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEIGH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Snapshot of the operands. These values are frozen for the whole scan.
    logic [W-1:0]       snap_self;
    logic [W-1:0]       snap_nbr [N_NEIGH];
    logic [CNT_W-1:0]   snap_thresh;
    logic [N_NEIGH-1:0] snap_mask;

    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   acc;

    logic               capture;
    logic               last;
    logic               finish;
    logic               hit;
    logic [N_NEIGH-1:0] mask_now;

`ifdef NBR_MASK_EN
    assign mask_now = nbr_mask;
`else
    assign mask_now = '1;
`endif

    assign last = (idx == LAST_IDX);
    assign busy = (state != IDLE);

    // Shared comparator: the neighbour selected by the scan index against self.
    always_comb begin
        hit = 1'b0;
        if (state == SCAN) begin
            hit = (snap_nbr[idx] == snap_self) && snap_mask[idx];
        end
    end

    // Next-state logic. Dropping high overrides every transition and returns to IDLE.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && high) begin
                    state_nxt = SCAN;
                    capture   = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                finish    = high;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!high) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand snapshot, loaded only on the edge that accepts start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_self   <= '0;
            snap_thresh <= '0;
            snap_mask   <= '0;
            for (int unsigned k = 0; k < N_NEIGH; k++) begin
                snap_nbr[k] <= '0;
            end
        end else if (capture) begin
            snap_self   <= self_in;
            snap_thresh <= thresh;
            snap_mask   <= mask_now;
            for (int unsigned k = 0; k < N_NEIGH; k++) begin
                snap_nbr[k] <= nbr_in[k*W +: W];
            end
        end
    end

    // Scan index and match accumulator. Both are cleared on abort and on a new start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            acc <= '0;
        end else if (!high || capture) begin
            idx <= '0;
            acc <= '0;
        end else if (state == SCAN) begin
            acc <= acc + CNT_W'(hit);
            // Wrap to 0 after the last neighbour so a non-power-of-two scan
            // never leaves an out-of-range index behind.
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    // Result registers. out pulses on the DONE->IDLE edge; match and count are held between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            out <= finish;
            if (finish) begin
                match_cnt <= acc;
                match     <= (acc >= snap_thresh);
            end
        end
    end

endmodule

// File: tb/tb_nbr_match_node.sv
// Self-checking bench for nbr_match_node. Instance A uses the default
// geometry (W=2, N_NEIGH=4). Instance B uses W=4 and N_NEIGH=7.
module tb_nbr_match_node;

    localparam int WA = 2;
    localparam int NA = 4;
    localparam int CA = 3;
    localparam int WB = 4;
    localparam int NB = 7;
    localparam int CB = 3;

    logic clk = 1'b0;
    logic rst;

    logic             high_a, start_a;
    logic [WA-1:0]    self_a;
    logic [NA*WA-1:0] nbr_a;
    logic [CA-1:0]    thresh_a;
    logic [NA-1:0]    mask_a;
    logic             busy_a, out_a, match_a;
    logic [CA-1:0]    cnt_a;

    logic             high_b, start_b;
    logic [WB-1:0]    self_b;
    logic [NB*WB-1:0] nbr_b;
    logic [CB-1:0]    thresh_b;
    logic [NB-1:0]    mask_b;
    logic             busy_b, out_b, match_b;
    logic [CB-1:0]    cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbr_match_node #(.W(WA), .N_NEIGH(NA), .CNT_W(CA)) dut_a (
        .clk(clk), .rst(rst), .high(high_a), .start(start_a),
        .self_in(self_a), .nbr_in(nbr_a), .thresh(thresh_a),
`ifdef NBR_MASK_EN
        .nbr_mask(mask_a),
`endif
        .busy(busy_a), .out(out_a), .match(match_a), .match_cnt(cnt_a)
    );

    nbr_match_node #(.W(WB), .N_NEIGH(NB), .CNT_W(CB)) dut_b (
        .clk(clk), .rst(rst), .high(high_b), .start(start_b),
        .self_in(self_b), .nbr_in(nbr_b), .thresh(thresh_b),
`ifdef NBR_MASK_EN
        .nbr_mask(mask_b),
`endif
        .busy(busy_b), .out(out_b), .match(match_b), .match_cnt(cnt_b)
    );

    // Reference: count the neighbour fields equal to self whose mask bit is set.
    function automatic int ref_count(input logic [63:0] self_v, input logic [63:0] nbr_v,
                                     input logic [63:0] mask_v, input int w, input int n);
        int c;
        logic [63:0] fmask;
        logic [63:0] field;
        c = 0;
        fmask = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) begin
            field = (nbr_v >> (k * w)) & fmask;
            if (mask_v[k] && (field == (self_v & fmask))) c++;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge on A (the start edge), then wait for out with a cycle bound.
    task automatic go_a(output int n);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (out_a !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic go_b(output int n);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (out_b !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        high_a = 1'b1; start_a = 1'b0; self_a = '0; nbr_a = '0; thresh_a = '0; mask_a = '1;
        high_b = 1'b1; start_b = 1'b0; self_b = '0; nbr_b = '0; thresh_b = '0; mask_b = '1;
        #2;
        checks++;
        if ({busy_a, out_a, match_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b out=%b match=%b cnt=%0d expected all 0",
                     busy_a, out_a, match_a, cnt_a);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        // Start a scan with a full match, then reset two cycles into SCAN.
        self_a = 2'b11; nbr_a = '1; thresh_a = 3'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_a, out_a, match_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_midscan busy=%b out=%b match=%b cnt=%0d expected all 0",
                     busy_a, out_a, match_a, cnt_a);
        end
        #3;
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < NA + 4; i++) begin
            tick();
            if (out_a === 1'b1) n++;
        end
        checks++;
        if (n != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse pulses=%0d busy=%b expected 0 and 0", n, busy_a);
        end
    endtask

    task automatic test_full_match();
        int n;
        self_a = 2'b11; nbr_a = '1; thresh_a = 3'd1; mask_a = '1;
        go_a(n);
        checks++;
        if (n != NA + 1 || cnt_a !== 3'd4 || match_a !== 1'b1) begin
            errors++;
            $display("FAIL full_match latency=%0d cnt=%0d match=%b expected %0d 4 1",
                     n, cnt_a, match_a, NA + 1);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0 || out_a !== 1'b0 || cnt_a !== 3'd4) begin
            errors++;
            $display("FAIL full_match_after busy=%b out=%b cnt=%0d expected 0 0 4",
                     busy_a, out_a, cnt_a);
        end
    endtask

    task automatic test_partial_thresh();
        int n;
        logic [2:0] th_list [3];
        logic       exp_m   [3];
        th_list[0] = 3'd3; exp_m[0] = 1'b0;
        th_list[1] = 3'd2; exp_m[1] = 1'b1;
        th_list[2] = 3'd1; exp_m[2] = 1'b1;
        self_a = 2'b01; nbr_a = 8'b01_10_01_00; mask_a = '1;
        for (int i = 0; i < 3; i++) begin
            thresh_a = th_list[i];
            go_a(n);
            checks++;
            if (n != NA + 1 || cnt_a !== 3'd2 || match_a !== exp_m[i]) begin
                errors++;
                $display("FAIL partial_th%0d latency=%0d cnt=%0d match=%b expected %0d 2 %b",
                         th_list[i], n, cnt_a, match_a, NA + 1, exp_m[i]);
            end
        end
        // thresh=0 with no equal neighbours still reports a match.
        self_a = 2'b11; nbr_a = 8'b00_01_10_00; thresh_a = 3'd0;
        go_a(n);
        checks++;
        if (cnt_a !== 3'd0 || match_a !== 1'b1) begin
            errors++;
            $display("FAIL thresh_zero cnt=%0d match=%b expected 0 1", cnt_a, match_a);
        end
        // thresh above N_NEIGH never matches, even with every neighbour equal.
        for (int t = NA + 1; t < 8; t++) begin
            self_a = 2'b10; nbr_a = 8'b10_10_10_10; thresh_a = 3'(t);
            go_a(n);
            checks++;
            if (cnt_a !== 3'd4 || match_a !== 1'b0) begin
                errors++;
                $display("FAIL thresh_over_%0d cnt=%0d match=%b expected 4 0", t, cnt_a, match_a);
            end
        end
    endtask

    task automatic test_snapshot();
        int pulses;
        logic [CA-1:0] seen_cnt;
        logic seen_match;
        tick();
        self_a = 2'b10; nbr_a = 8'b10_10_10_10; thresh_a = 3'd1; mask_a = '1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        self_a = 2'b01; nbr_a = '0; thresh_a = 3'd7; mask_a = '0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        pulses = 0; seen_cnt = '0; seen_match = 1'b0;
        for (int i = 0; i < 3 * (NA + 2); i++) begin
            tick();
            if (out_a === 1'b1) begin
                pulses++;
                seen_cnt = cnt_a;
                seen_match = match_a;
            end
        end
        checks++;
        if (pulses != 1 || seen_cnt !== 3'd4 || seen_match !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL snapshot pulses=%0d cnt=%0d match=%b busy=%b expected 1 4 1 0",
                     pulses, seen_cnt, seen_match, busy_a);
        end
    endtask

    task automatic test_abort();
        int n, pulses, c;
        logic [CA-1:0] prior;
        self_a = 2'b00; nbr_a = 8'b00_11_00_11; thresh_a = 3'd2; mask_a = '1;
        go_a(n);
        prior = cnt_a;
        checks++;
        if (prior !== 3'd2) begin
            errors++;
            $display("FAIL abort_prior cnt=%0d expected 2", prior);
        end
        self_a = 2'b01; nbr_a = 8'b01_01_01_01; thresh_a = 3'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        high_a = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || out_a !== 1'b0 || cnt_a !== prior || match_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_state busy=%b out=%b cnt=%0d match=%b expected 0 0 %0d 1",
                     busy_a, out_a, cnt_a, match_a, prior);
        end
        // high=0 with start=1 in IDLE must not start a scan.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL start_while_low busy=%b expected 0", busy_a);
        end
        high_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < NA + 4; i++) begin
            tick();
            if (out_a === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || cnt_a !== prior) begin
            errors++;
            $display("FAIL abort_no_pulse pulses=%0d cnt=%0d expected 0 %0d", pulses, cnt_a, prior);
        end
        self_a = WA'($urandom); nbr_a = NA*WA'($urandom); thresh_a = CA'($urandom_range(4));
        c = ref_count(64'(self_a), 64'(nbr_a), 64'(mask_a), WA, NA);
        go_a(n);
        checks++;
        if (n != NA + 1 || cnt_a !== CA'(c) || match_a !== (c >= int'(thresh_a))) begin
            errors++;
            $display("FAIL abort_restart latency=%0d cnt=%0d match=%b expected %0d %0d %b",
                     n, cnt_a, match_a, NA + 1, c, c >= int'(thresh_a));
        end
    endtask

    task automatic test_back_to_back();
        int n, c;
        logic em;
        for (int i = 0; i < 30; i++) begin
            self_a = WA'($urandom);
            for (int k = 0; k < NA; k++)
                nbr_a[k*WA +: WA] = ($urandom_range(1) == 1) ? self_a : WA'($urandom);
            thresh_a = CA'($urandom);
`ifdef NBR_MASK_EN
            mask_a = NA'($urandom);
`else
            mask_a = '1;
`endif
            c = ref_count(64'(self_a), 64'(nbr_a), 64'(mask_a), WA, NA);
            em = (c >= int'(thresh_a));
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept_%0d busy=%b expected 1", i, busy_a);
            end
            n = 0;
            while (out_a !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            checks++;
            if (n != NA + 1 || cnt_a !== CA'(c) || match_a !== em) begin
                errors++;
                $display("FAIL b2b_%0d latency=%0d cnt=%0d match=%b expected %0d %0d %b",
                         i, n, cnt_a, match_a, NA + 1, c, em);
            end
        end
        mask_a = '1;
    endtask

    task automatic test_param_sweep();
        int n, c;
        logic em;
        tick();
        self_b = WB'($urandom);
        for (int k = 0; k < NB; k++) nbr_b[k*WB +: WB] = self_b;
        thresh_b = 3'd7; mask_b = '1;
        go_b(n);
        checks++;
        if (n != NB + 1 || cnt_b !== 3'd7 || match_b !== 1'b1) begin
            errors++;
            $display("FAIL sweep_full latency=%0d cnt=%0d match=%b expected %0d 7 1",
                     n, cnt_b, match_b, NB + 1);
        end
`ifdef NBR_MASK_EN
        tick();
        mask_b = 7'b0000101; thresh_b = 3'd2;
        go_b(n);
        checks++;
        if (cnt_b !== 3'd2 || match_b !== 1'b1) begin
            errors++;
            $display("FAIL sweep_mask cnt=%0d match=%b expected 2 1", cnt_b, match_b);
        end
        tick();
        mask_b = '0; thresh_b = 3'd1;
        go_b(n);
        checks++;
        if (cnt_b !== 3'd0 || match_b !== 1'b0) begin
            errors++;
            $display("FAIL sweep_mask_zero cnt=%0d match=%b expected 0 0", cnt_b, match_b);
        end
        mask_b = '1;
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            self_b = WB'($urandom);
            for (int k = 0; k < NB; k++)
                nbr_b[k*WB +: WB] = ($urandom_range(2) != 0) ? self_b : WB'($urandom);
            thresh_b = CB'($urandom);
            c = ref_count(64'(self_b), 64'(nbr_b), 64'(mask_b), WB, NB);
            em = (c >= int'(thresh_b));
            go_b(n);
            checks++;
            if (n != NB + 1 || cnt_b !== CB'(c) || match_b !== em) begin
                errors++;
                $display("FAIL sweep_rand_%0d latency=%0d cnt=%0d match=%b expected %0d %0d %b",
                         i, n, cnt_b, match_b, NB + 1, c, em);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_match();
        test_partial_thresh();
        test_snapshot();
        test_abort();
        test_back_to_back();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbr_match_node.md
Name: nbr_match_node

Overview:
Parametrised neighbour-match node. It compares its own W-bit state against N_NEIGH neighbour states, one neighbour per clock, through a single shared equality comparator. It counts the matches and reports a thresholded match flag plus the raw count with a one-cycle valid pulse. It sits in the node array as the generalised successor of the fixed 4-neighbour, 2-bit OR-match node and adds a start/busy handshake, input snapshotting, a match threshold and abort-on-disable.

Parameters:
W, 2, bit width of node state and of each neighbour state
N_NEIGH, 4, number of neighbours scanned (>=1)
CNT_W, 3, width of match count and threshold; must satisfy 2^CNT_W > N_NEIGH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
high  input  1  node enable; 0 forces idle and aborts any scan
start  input  1  scan request, sampled only in IDLE with high=1
self_in  input  W  own state
nbr_in  input  N_NEIGH*W  neighbour states, neighbour k at bits [k*W +: W]
thresh  input  CNT_W  minimum match count for match=1, sampled with start
busy  output  1  1 while in SCAN or DONE
out  output  1  one-cycle result-valid pulse
match  output  1  (match_cnt >= thresh), valid while out=1, held until next out
match_cnt  output  CNT_W  number of equal neighbours, held until next out

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, out=0, match=0, match_cnt=0; index, accumulator and snapshot registers are cleared.
- States are IDLE, SCAN and DONE.
- IDLE -> SCAN when start=1 and high=1.
  - On that edge, self_in, all of nbr_in and thresh are captured into snapshot registers.
  - Input changes after capture do not affect the result.
  - Index is set to 0 and the accumulator to 0.
- SCAN runs one neighbour per cycle.
  - If snap_nbr[index] == snap_self, the accumulator increments by 1.
  - Index increments each cycle.
  - When index == N_NEIGH-1 (last compare done on this edge), go to DONE.
  - The accumulator never exceeds N_NEIGH, so there is no overflow.
- DONE lasts exactly one cycle.
  - out=1, match_cnt=accumulator, match=(accumulator >= snap_thresh), unsigned compare.
  - Next state is IDLE.
- Latency: start sampled at edge 0 -> out=1 in the cycle after edge N_NEIGH+1. A new start is accepted in the first IDLE cycle after DONE, giving throughput of one result per N_NEIGH+2 cycles.
- start while busy=1 is ignored (not queued).
- high=0 in any state:
  - next edge goes to IDLE with out=0;
  - the accumulator and index are cleared;
  - match and match_cnt keep their previous values;
  - an aborted scan never produces an out pulse.
- high=0 together with start=1 in IDLE: no scan starts.
- thresh=0: match=1 on every completed scan.
- thresh>N_NEIGH: match=0 on every completed scan.
- out is registered; match and match_cnt update on the same edge out rises.

Optional Feature:
NBR_MASK_EN:
- Defined: adds input port nbr_mask [N_NEIGH-1:0], captured with start. A neighbour whose mask bit is 0 is still scanned (timing unchanged) but never counted. Mask all-zero gives match_cnt=0, and match=1 only if thresh=0.
- Undefined: the port is absent and every neighbour is counted.

Test Plan:
1. Reset mid-SCAN: W=2, N_NEIGH=4, start then pull rst=0 after 2 cycles -> busy, out, match, match_cnt all 0 immediately; no out pulse after rst releases.
2. Full match: self_in=2'b11, nbr_in all 2'b11, thresh=1, start -> out=1 exactly 5 cycles after start edge, match_cnt=4, match=1, busy=0 the following cycle.
3. Partial match and threshold: self_in=2'b01, nbr_in={01,10,01,00} (k3..k0), thresh=3 -> match_cnt=2, match=0. Repeat with thresh=2 -> match=1. Repeat with thresh=0 and no matches -> match=1.
4. Snapshot and ignored start: start with self_in=2'b10 and all neighbours 2'b10, then change all nbr_in to 2'b00 and pulse start during SCAN -> match_cnt=4; only one out pulse.
5. Abort: start, drop high for 1 cycle at SCAN index 1 -> no out pulse, match_cnt keeps its prior value. Re-raise high, start again -> normal result 5 cycles later.
6. Parameter sweep: W=4, N_NEIGH=7, CNT_W=3, all neighbours equal -> match_cnt=7, out 8 cycles after start. With NBR_MASK_EN and mask=7'b0000101 -> match_cnt=2.
